// File: rtl/kbjoy_pkg.sv
// Shared scancodes, joystick bit positions and PS/2 frame states for the
// arcade_kbd_joy keyboard front end.
package kbjoy_pkg;

  localparam int JOY_W = 10;

  localparam logic [7:0] SC_E0    = 8'hE0;
  localparam logic [7:0] SC_F0    = 8'hF0;
  localparam logic [7:0] SC_E1    = 8'hE1;

  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_1     = 8'h16;
  localparam logic [7:0] SC_2     = 8'h1E;
  localparam logic [7:0] SC_5     = 8'h2E;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_LCTRL = 8'h14;
  localparam logic [7:0] SC_LALT  = 8'h11;

  localparam int JB_FIRE   = 0;
  localparam int JB_START1 = 1;
  localparam int JB_START2 = 2;
  localparam int JB_COIN   = 3;
  localparam int JB_LEFT   = 4;
  localparam int JB_RIGHT  = 5;
  localparam int JB_DOWN   = 6;
  localparam int JB_UP     = 7;
  localparam int JB_FIRE2  = 8;
  localparam int JB_FIRE3  = 9;

  // Bytes swallowed after an E1 prefix (tail of the Pause make sequence).
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } frameState_t;

  // One-hot joystick bit for a scancode; zero when the (ext, code) pair is unmapped.
  function automatic logic [JOY_W-1:0] keyMask(input logic ext, input logic [7:0] code);
    logic [JOY_W-1:0] m;
    m = '0;
    if (!ext) begin
      case (code)
        SC_SPACE: m[JB_FIRE]   = 1'b1;
        SC_1:     m[JB_START1] = 1'b1;
        SC_2:     m[JB_START2] = 1'b1;
        SC_5:     m[JB_COIN]   = 1'b1;
        SC_LCTRL: m[JB_FIRE2]  = 1'b1;
        SC_LALT:  m[JB_FIRE3]  = 1'b1;
        default:  m = '0;
      endcase
    end else begin
      case (code)
        SC_LEFT:  m[JB_LEFT]  = 1'b1;
        SC_RIGHT: m[JB_RIGHT] = 1'b1;
        SC_DOWN:  m[JB_DOWN]  = 1'b1;
        SC_UP:    m[JB_UP]    = 1'b1;
        default:  m = '0;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 receive path: synchroniser, run-length glitch filter, frame FSM and
// inactivity timeout. Odd-parity checking is enabled by KBJOY_PARITY_EN.
module ps2_rx
  import kbjoy_pkg::*;
#(
  parameter int FILT_LEN       = 8,
  parameter int TIMEOUT_CYCLES = 18000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_kbd_clk,
  input  logic       ps2_kbd_data,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int FW = $clog2(FILT_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    r_clkSync;
  logic [1:0]    r_datSync;
  logic          r_clkFilt;
  logic          r_datFilt;
  logic [FW-1:0] r_clkCnt;
  logic [FW-1:0] r_datCnt;
  logic          r_clkPrev;
  logic          w_strobe;

  frameState_t   r_state;
  frameState_t   w_stateNext;
  logic [2:0]    r_bitCnt;
  logic [2:0]    w_bitCntNext;
  logic [7:0]    r_shift;
  logic [7:0]    w_shiftNext;
  logic [TW-1:0] r_toCnt;
  logic [TW-1:0] w_toNext;
  logic          w_emit;
  logic          w_err;
  logic          w_parOk;
  logic          r_byteValid;
  logic [7:0]    r_byteData;
  logic          r_frameErr;

  // Sync flops and filters idle high so a released bus never looks like a start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clkSync <= 2'b11;
      r_datSync <= 2'b11;
    end else begin
      r_clkSync <= {r_clkSync[0], ps2_kbd_clk};
      r_datSync <= {r_datSync[0], ps2_kbd_data};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clkFilt <= 1'b1;
      r_clkCnt  <= '0;
      r_clkPrev <= 1'b1;
    end else begin
      r_clkPrev <= r_clkFilt;
      if (r_clkSync[1] == r_clkFilt) begin
        r_clkCnt <= '0;
      end else if (r_clkCnt == FW'(FILT_LEN - 1)) begin
        r_clkFilt <= r_clkSync[1];
        r_clkCnt  <= '0;
      end else begin
        r_clkCnt <= r_clkCnt + FW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_datFilt <= 1'b1;
      r_datCnt  <= '0;
    end else begin
      if (r_datSync[1] == r_datFilt) begin
        r_datCnt <= '0;
      end else if (r_datCnt == FW'(FILT_LEN - 1)) begin
        r_datFilt <= r_datSync[1];
        r_datCnt  <= '0;
      end else begin
        r_datCnt <= r_datCnt + FW'(1);
      end
    end
  end

  assign w_strobe = r_clkPrev & ~r_clkFilt;

`ifdef KBJOY_PARITY_EN
  logic r_parOk;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_parOk <= 1'b0;
    end else if (w_strobe && (r_state == PARITY)) begin
      r_parOk <= ^{r_shift, r_datFilt};
    end
  end

  assign w_parOk = r_parOk;
`else
  assign w_parOk = 1'b1;
`endif

  // A strobe takes priority over the timeout so a late-but-live frame survives.
  always_comb begin
    w_stateNext  = r_state;
    w_bitCntNext = r_bitCnt;
    w_shiftNext  = r_shift;
    w_toNext     = r_toCnt;
    w_emit       = 1'b0;
    w_err        = 1'b0;
    if (w_strobe) begin
      w_toNext = '0;
      case (r_state)
        IDLE: begin
          if (!r_datFilt) begin
            w_stateNext  = DATA;
            w_bitCntNext = '0;
          end
        end
        DATA: begin
          w_shiftNext  = {r_datFilt, r_shift[7:1]};
          w_bitCntNext = r_bitCnt + 3'd1;
          if (r_bitCnt == 3'd7) w_stateNext = PARITY;
        end
        PARITY: begin
          w_stateNext = STOP;
        end
        STOP: begin
          if (r_datFilt && w_parOk) w_emit = 1'b1;
          else                      w_err  = 1'b1;
          w_stateNext = IDLE;
        end
        default: w_stateNext = IDLE;
      endcase
    end else if (r_state == IDLE) begin
      w_toNext = '0;
    end else if (r_toCnt == TW'(TIMEOUT_CYCLES - 1)) begin
      w_toNext    = '0;
      w_stateNext = IDLE;
      w_err       = 1'b1;
    end else begin
      w_toNext = r_toCnt + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_bitCnt    <= '0;
      r_shift     <= '0;
      r_toCnt     <= '0;
      r_byteValid <= 1'b0;
      r_byteData  <= '0;
      r_frameErr  <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_bitCnt    <= w_bitCntNext;
      r_shift     <= w_shiftNext;
      r_toCnt     <= w_toNext;
      r_byteValid <= w_emit;
      r_frameErr  <= w_err;
      if (w_emit) r_byteData <= r_shift;
    end
  end

  assign byte_valid = r_byteValid;
  assign byte_data  = r_byteData;
  assign frame_err  = r_frameErr;

endmodule

// File: rtl/arcade_kbd_joy.sv
// PS/2 set-2 keyboard to 10-bit arcade joystick vector: prefix tracking,
// Pause-sequence skipping and key map. Optional parity check: KBJOY_PARITY_EN.
module arcade_kbd_joy
  import kbjoy_pkg::*;
#(
  parameter int FILT_LEN       = 8,
  parameter int TIMEOUT_CYCLES = 18000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ps2_kbd_clk,
  input  logic             ps2_kbd_data,
  output logic [JOY_W-1:0] joystick,
  output logic             frame_err
);

  logic             w_byteValid;
  logic [7:0]       w_byteData;
  logic [JOY_W-1:0] w_mask;
  logic             r_ext;
  logic             r_brk;
  logic [2:0]       r_skip;
  logic [JOY_W-1:0] r_joy;

  ps2_rx #(
    .FILT_LEN      (FILT_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk         (clk),
    .reset       (reset),
    .ps2_kbd_clk (ps2_kbd_clk),
    .ps2_kbd_data(ps2_kbd_data),
    .byte_valid  (w_byteValid),
    .byte_data   (w_byteData),
    .frame_err   (frame_err)
  );

  assign w_mask = keyMask(r_ext, w_byteData);

  // Prefixes only latch state; any other byte consumes them whether mapped or not.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ext  <= 1'b0;
      r_brk  <= 1'b0;
      r_skip <= '0;
      r_joy  <= '0;
    end else if (w_byteValid) begin
      if (r_skip != 3'd0) begin
        r_skip <= r_skip - 3'd1;
      end else if (w_byteData == SC_E0) begin
        r_ext <= 1'b1;
      end else if (w_byteData == SC_F0) begin
        r_brk <= 1'b1;
      end else if (w_byteData == SC_E1) begin
        r_skip <= PAUSE_SKIP;
      end else begin
        r_joy <= r_brk ? (r_joy & ~w_mask) : (r_joy | w_mask);
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end
    end
  end

  assign joystick = r_joy;

endmodule

// File: tb/tb_arcade_kbd_joy.sv
// Scoreboard bench for arcade_kbd_joy: stimulus pushes expected output events,
// a negedge monitor pops and compares them. Honours KBJOY_PARITY_EN.
module tb_arcade_kbd_joy;

  localparam int H = 20;

  typedef struct {
    int         cyc;
    logic [9:0] joy;
    logic       err;
  } exp_t;

  logic       clk    = 1'b0;
  logic       reset  = 1'b1;
  logic       ps2Clk = 1'b1;
  logic       ps2Dat = 1'b1;
  logic [9:0] joystick;
  logic       frame_err;
  logic       monOn  = 1'b0;
  logic [9:0] lastJoy = '0;
  logic [9:0] pb;
  int         cyc    = 0;
  int         checks = 0;
  int         errors = 0;
  exp_t       expQ[$];

  arcade_kbd_joy dut (
    .clk         (clk),
    .reset       (reset),
    .ps2_kbd_clk (ps2Clk),
    .ps2_kbd_data(ps2Dat),
    .joystick    (joystick),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: any joystick change or frame_err pulse is a DUT output event.
  // cyc < 0 in an expectation means the event time is not pinned down.
  always @(negedge clk) begin
    exp_t e;
    if (monOn && (joystick !== lastJoy || frame_err !== 1'b0)) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_output: got joy=%h err=%b cyc=%0d, required no output",
                 joystick, frame_err, cyc);
      end else begin
        e = expQ.pop_front();
        if (joystick !== e.joy || frame_err !== e.err || (e.cyc >= 0 && cyc != e.cyc)) begin
          errors++;
          $display("[TB] FAIL output_event: got joy=%h err=%b cyc=%0d, required joy=%h err=%b cyc=%0d",
                   joystick, frame_err, cyc, e.joy, e.err, e.cyc);
        end
      end
      lastJoy = joystick;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, required);
    end
  endtask

  // Drives nFalls bits of a frame (11 = complete). The expectation is queued
  // just before the stop-bit fall: error pulses land 11 clks after it, key
  // updates 12 clks after it (sync 2 + filter 8 + strobe/emit + decode).
  task automatic applyStimulus(input logic [7:0] code, input logic stopBit,
                               input logic badPar, input int nFalls,
                               input logic expEvt, input logic [9:0] expJoy,
                               input logic expErr);
    logic [10:0] bits;
    exp_t        e;
    bits = {stopBit, (~^code) ^ badPar, code, 1'b0};
    for (int i = 0; i < nFalls; i++) begin
      @(posedge clk); #1;
      ps2Dat = bits[i];
      repeat (H) @(posedge clk);
      #1;
      if (i == 10 && expEvt) begin
        e.cyc = cyc + (expErr ? 11 : 12);
        e.joy = expJoy;
        e.err = expErr;
        expQ.push_back(e);
      end
      ps2Clk = 1'b0;
      repeat (H) @(posedge clk);
      #1;
      ps2Clk = 1'b1;
    end
    ps2Dat = 1'b1;
    repeat (3 * H) @(posedge clk);
  endtask

  task automatic sendKey(input logic [7:0] code, input logic [9:0] expJoy);
    applyStimulus(code, 1'b1, 1'b0, 11, 1'b1, expJoy, 1'b0);
  endtask

  task automatic sendQuiet(input logic [7:0] code);
    applyStimulus(code, 1'b1, 1'b0, 11, 1'b0, '0, 1'b0);
  endtask

  task automatic pushAnyTime(input logic [9:0] joy, input logic err);
    exp_t e;
    e.cyc = -1;
    e.joy = joy;
    e.err = err;
    expQ.push_back(e);
  endtask

  initial begin
`ifdef KBJOY_PARITY_EN
    pb = 10'h000;
`else
    pb = 10'h002;
`endif
    repeat (4) @(posedge clk);
    #1;
    checkOutput("reset_joystick", 32'(joystick), 32'h0);
    checkOutput("reset_frame_err", 32'(frame_err), 32'h0);
    reset = 1'b0;
    monOn = 1'b1;
    repeat (10) @(posedge clk);

    // Fire make then break.
    sendKey(8'h29, 10'h001);
    sendQuiet(8'hF0);
    sendKey(8'h29, 10'h000);

    // Extended arrows; plain 6B is keypad 4 and must be ignored.
    sendQuiet(8'hE0);
    sendKey(8'h75, 10'h080);
    sendQuiet(8'hE0);
    sendKey(8'h6B, 10'h090);
    sendQuiet(8'hE0);
    sendQuiet(8'hF0);
    sendKey(8'h75, 10'h010);
    sendQuiet(8'h6B);

    // Start1 with inverted parity bit.
`ifdef KBJOY_PARITY_EN
    applyStimulus(8'h16, 1'b1, 1'b1, 11, 1'b1, 10'h010, 1'b1);
`else
    applyStimulus(8'h16, 1'b1, 1'b1, 11, 1'b1, 10'h012, 1'b0);
`endif

    // Abandoned frame after 4 data bits: one timeout pulse, then recovery.
    pushAnyTime(10'h010 | pb, 1'b1);
    applyStimulus(8'h2E, 1'b1, 1'b0, 5, 1'b0, '0, 1'b0);
    repeat (20000) @(posedge clk);
    sendKey(8'h2E, 10'h018 | pb);

    // Pause sequence: the seven bytes after E1 are dropped.
    sendQuiet(8'hE1);
    sendQuiet(8'h14);
    sendQuiet(8'h77);
    sendQuiet(8'hE1);
    sendQuiet(8'hF0);
    sendQuiet(8'h14);
    sendQuiet(8'hF0);
    sendQuiet(8'h77);
    sendKey(8'h11, 10'h218 | pb);

    // Remaining keys; E0 14 is RCtrl and must not touch fire2.
    sendKey(8'h1E, 10'h21C | pb);
    sendQuiet(8'hE0);
    sendKey(8'h74, 10'h23C | pb);
    sendQuiet(8'hE0);
    sendKey(8'h72, 10'h27C | pb);
    sendKey(8'h14, 10'h37C | pb);
    sendQuiet(8'hE0);
    sendQuiet(8'h14);
    sendQuiet(8'hF0);
    sendKey(8'h14, 10'h27C | pb);

    // Bad stop bit: framing error, key dropped.
    applyStimulus(8'h29, 1'b0, 1'b0, 11, 1'b1, 10'h27C | pb, 1'b1);

    // 3-clk glitch on the PS/2 clock with data low must not start a frame.
    @(posedge clk); #1;
    ps2Dat = 1'b0;
    repeat (H) @(posedge clk);
    #1;
    ps2Clk = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    ps2Clk = 1'b1;
    repeat (H) @(posedge clk);
    #1;
    ps2Dat = 1'b1;
    repeat (H) @(posedge clk);
    sendQuiet(8'hF0);
    sendKey(8'h1E, 10'h278 | pb);

    // Reset in the middle of a frame clears outputs asynchronously.
    pushAnyTime(10'h000, 1'b0);
    applyStimulus(8'h29, 1'b1, 1'b0, 3, 1'b0, '0, 1'b0);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("midframe_reset_joystick", 32'(joystick), 32'h0);
    checkOutput("midframe_reset_frame_err", 32'(frame_err), 32'h0);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (10) @(posedge clk);
    sendKey(8'h29, 10'h001);

    repeat (100) @(posedge clk);
    checkOutput("expected_events_left", 32'(expQ.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
